// File: rtl/axi_pkg.sv
// Shared AXI constants and the bridge FSM encoding used by the SRAM-to-AXI bridge.
package axi_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [7:0] LEN_SINGLE  = 8'd0;
  localparam int         DEF_INST_ID = 0;
  localparam int         DEF_DATA_ID = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_ADDR = 3'd3,
    ST_WR_RESP = 3'd4
  } bridge_state_e;

endpackage

// File: rtl/sram_axi_strb.sv
// Byte-lane strobe for a single-beat write from the SRAM-style size and low address bits.
module sram_axi_strb (
  input  logic [1:0] size_i,
  input  logic [1:0] addr_lo_i,
  output logic [3:0] wstrb_o
);

  always_comb begin
    wstrb_o = 4'b1111;
    case (size_i)
      2'd0:    wstrb_o = 4'b0001 << addr_lo_i;
      2'd1:    wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
      default: wstrb_o = 4'b1111;
    endcase
  end

endmodule

// File: rtl/sram_axi_bridge.sv
// Merges instruction/data SRAM-like ports onto one AXI4 master, one single-beat
// transaction outstanding at a time; data side wins simultaneous requests.
module sram_axi_bridge
  import axi_pkg::*;
#(
  parameter int ID_W    = 4,
  parameter int INST_ID = DEF_INST_ID,
  parameter int DATA_ID = DEF_DATA_ID
) (
  input  logic            clk,
  input  logic            rst,
  // instruction side
  input  logic            inst_req,
  input  logic            inst_wr,
  input  logic [1:0]      inst_size,
  input  logic [31:0]     inst_addr,
  input  logic [31:0]     inst_wdata,
  output logic [31:0]     inst_rdata,
  output logic            inst_addr_ok,
  output logic            inst_data_ok,
  // data side
  input  logic            data_req,
  input  logic            data_wr,
  input  logic [1:0]      data_size,
  input  logic [31:0]     data_addr,
  input  logic [31:0]     data_wdata,
  output logic [31:0]     data_rdata,
  output logic            data_addr_ok,
  output logic            data_data_ok,
  // AR
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic            arlock,
  output logic [3:0]      arcache,
  output logic [2:0]      arprot,
  output logic            arvalid,
  input  logic            arready,
  // R
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  // AW
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic [7:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic            awlock,
  output logic [3:0]      awcache,
  output logic [2:0]      awprot,
  output logic            awvalid,
  input  logic            awready,
  // W
  output logic [ID_W-1:0] wid,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  // B
  input  logic [ID_W-1:0] bid,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready,
  // debug
  output bridge_state_e   dbg_state_o
);

  localparam logic [ID_W-1:0] INST_ID_L = ID_W'(INST_ID);
  localparam logic [ID_W-1:0] DATA_ID_L = ID_W'(DATA_ID);

  bridge_state_e state_q, state_d;
  logic          src_data_q, src_data_d;
  logic [1:0]    size_q, size_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          aw_done_q, aw_done_d;
  logic          w_done_q, w_done_d;
  logic [3:0]    strb;

  // IDs, responses and inst-side write intent carry no information for this bridge.
  logic unused_inputs;
  assign unused_inputs = ^{rid, rresp, rlast, bid, bresp, inst_wr, inst_wdata};

  wire in_idle = (state_q == ST_IDLE);

  assign data_addr_ok = in_idle && data_req;
  assign inst_addr_ok = in_idle && !data_req && inst_req;

  always_comb begin
    state_d    = state_q;
    src_data_d = src_data_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    case (state_q)
      ST_IDLE: begin
        if (data_req) begin
          src_data_d = 1'b1;
          size_d     = data_size;
          addr_d     = data_addr;
          wdata_d    = data_wdata;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          state_d    = data_wr ? ST_WR_ADDR : ST_RD_ADDR;
        end else if (inst_req) begin
          src_data_d = 1'b0;
          size_d     = inst_size;
          addr_d     = inst_addr;
          wdata_d    = '0;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          state_d    = ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: if (arready) state_d = ST_RD_DATA;
      ST_RD_DATA: if (rvalid)  state_d = ST_IDLE;
      ST_WR_ADDR: begin
        // AW and W complete independently, in either order.
        if (awready) aw_done_d = 1'b1;
        if (wready)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: if (bvalid) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      src_data_q <= 1'b0;
      size_q     <= 2'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_data_q <= src_data_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  sram_axi_strb u_strb (
    .size_i    (size_q),
    .addr_lo_i (addr_q[1:0]),
    .wstrb_o   (strb)
  );

  assign arid    = src_data_q ? DATA_ID_L : INST_ID_L;
  assign araddr  = addr_q;
  assign arlen   = LEN_SINGLE;
  assign arsize  = {1'b0, size_q};
  assign arburst = BURST_INCR;
  assign arlock  = 1'b0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = (state_q == ST_RD_ADDR);

  assign rready  = (state_q == ST_RD_DATA);

  assign awid    = DATA_ID_L;
  assign awaddr  = addr_q;
  assign awlen   = LEN_SINGLE;
  assign awsize  = {1'b0, size_q};
  assign awburst = BURST_INCR;
  assign awlock  = 1'b0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awvalid = (state_q == ST_WR_ADDR) && !aw_done_q;

  assign wid     = DATA_ID_L;
  assign wdata   = wdata_q;
  assign wstrb   = strb;
  assign wlast   = 1'b1;
  assign wvalid  = (state_q == ST_WR_ADDR) && !w_done_q;

  assign bready  = (state_q == ST_WR_RESP);

  wire rd_done = rready && rvalid;
  wire wr_done = bready && bvalid;

  assign inst_data_ok = rd_done && !src_data_q;
  assign data_data_ok = (rd_done && src_data_q) || wr_done;
  assign inst_rdata   = inst_data_ok ? rdata : 32'd0;
  assign data_rdata   = (rd_done && src_data_q) ? rdata : 32'd0;

  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: the testbench plays both the cache and the AXI slave.
module tb_sram_axi_bridge;
  import axi_pkg::*;

  localparam int ID_W = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            inst_req = 0, inst_wr = 0;
  logic [1:0]      inst_size = 0;
  logic [31:0]     inst_addr = 0, inst_wdata = 0;
  logic [31:0]     inst_rdata;
  logic            inst_addr_ok, inst_data_ok;
  logic            data_req = 0, data_wr = 0;
  logic [1:0]      data_size = 0;
  logic [31:0]     data_addr = 0, data_wdata = 0;
  logic [31:0]     data_rdata;
  logic            data_addr_ok, data_data_ok;
  logic [ID_W-1:0] arid, awid, wid;
  logic [31:0]     araddr, awaddr, wdata;
  logic [7:0]      arlen, awlen;
  logic [2:0]      arsize, awsize, arprot, awprot;
  logic [1:0]      arburst, awburst;
  logic            arlock, awlock;
  logic [3:0]      arcache, awcache, wstrb;
  logic            arvalid, awvalid, wvalid, wlast, rready, bready;
  logic            arready = 0, awready = 0, wready = 0;
  logic [ID_W-1:0] rid = 0, bid = 0;
  logic [31:0]     rdata = 0;
  logic [1:0]      rresp = 0, bresp = 0;
  logic            rlast = 0, rvalid = 0, bvalid = 0;
  bridge_state_e   dbg_state;

  int vectors = 0;
  int miscompares = 0;
  logic [32:0] exp_q[$];

  sram_axi_bridge #(.ID_W(ID_W), .INST_ID(0), .DATA_ID(1)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {arvalid, awvalid, wvalid, rready, bready, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}
  function automatic logic [31:0] hs_bits();
    return {23'd0, arvalid, awvalid, wvalid, rready, bready,
            inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok};
  endfunction

  // drivers
  task automatic finish_read(input bit is_data, input logic [31:0] rd);
    arready = 1; tick(); arready = 0;
    rvalid = 1; rdata = rd; #1;
    check("rd_ok", {30'd0, inst_data_ok, data_data_ok}, is_data ? 32'd1 : 32'd2);
    check("rd_data", is_data ? data_rdata : inst_rdata, rd);
    tick(); rvalid = 0; #1;
    check("rd_ok_pulse", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
  endtask

  task automatic write_txn(input logic [31:0] addr, input logic [1:0] size,
                           input logic [31:0] wd, input logic [3:0] exp_strb, input int w_gap);
    data_req = 1; data_wr = 1; data_addr = addr; data_size = size; data_wdata = wd; #1;
    check("wr_accept", {31'd0, data_addr_ok}, 32'd1);
    tick(); data_req = 0; data_wr = 0;
    check("wr_av", {30'd0, awvalid, wvalid}, 32'd3);
    check("wr_strb", {28'd0, wstrb}, {28'd0, exp_strb});
    check("wr_addr", awaddr, addr);
    check("wr_wdata", wdata, wd);
    check("wr_ids", {wid, awid, 23'd0, wlast}, {4'd1, 4'd1, 23'd0, 1'b1});
    awready = 1; wready = (w_gap == 0); tick(); awready = 0; wready = 0;
    if (w_gap > 0) begin
      for (int i = 0; i < w_gap - 1; i++) begin
        check("wr_wait", {29'd0, awvalid, wvalid, bready}, 32'b010);
        tick();
      end
      check("wr_wait_last", {29'd0, awvalid, wvalid, bready}, 32'b010);
      wready = 1; tick(); wready = 0;
    end
    check("wr_resp_st", {29'd0, awvalid, wvalid, bready}, 32'b001);
    bvalid = 1; #1;
    check("wr_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd1);
    tick(); bvalid = 0; #1;
    check("wr_ok_pulse", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
  endtask

  // one randomly timed transaction; completions are scoreboarded through exp_q
  task automatic random_txn(input int n);
    bit          side;
    bit          wr;
    logic [31:0] rd;
    logic [32:0] e;
    int          d, a, w;
    side = 1'($urandom_range(0, 1));
    wr   = side ? 1'($urandom_range(0, 1)) : 1'b0;
    rd   = $urandom;
    if (side) begin
      data_req = 1; data_wr = wr; data_addr = {$urandom} & 32'hFFFF_FFFC; data_size = 2;
    end else begin
      inst_req = 1; inst_addr = {$urandom} & 32'hFFFF_FFFC; inst_size = 2;
    end
    #1;
    check($sformatf("rnd%0d_acc", n), {30'd0, inst_addr_ok, data_addr_ok},
          side ? 32'd1 : 32'd2);
    exp_q.push_back({side, wr ? 32'd0 : rd});
    tick(); data_req = 0; inst_req = 0; data_wr = 0;
    if (!wr) begin
      d = $urandom_range(0, 3);
      repeat (d) tick();
      arready = 1; tick(); arready = 0;
      d = $urandom_range(0, 3);
      repeat (d) tick();
      rvalid = 1; rdata = rd; #1;
    end else begin
      a = $urandom_range(0, 3);
      w = $urandom_range(0, 3);
      for (int c = 0; c <= ((a > w) ? a : w); c++) begin
        awready = (c == a); wready = (c == w); tick();
      end
      awready = 0; wready = 0;
      d = $urandom_range(0, 3);
      repeat (d) tick();
      bvalid = 1; #1;
    end
    e = exp_q.pop_front();
    check($sformatf("rnd%0d_side", n), {30'd0, inst_data_ok, data_data_ok},
          e[32] ? 32'd1 : 32'd2);
    if (!wr) check($sformatf("rnd%0d_rdata", n), e[32] ? data_rdata : inst_rdata, e[31:0]);
    tick(); rvalid = 0; bvalid = 0; #1;
    check($sformatf("rnd%0d_once", n), {30'd0, inst_data_ok, data_data_ok}, 32'd0);
  endtask

  initial begin
    // reset state
    repeat (2) tick();
    check("rst_hs", hs_bits(), 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    check("rst_araddr", araddr, 32'd0);
    rst = 0;
    tick();

    // single inst read
    inst_req = 1; inst_addr = 32'hBFC0_0000; inst_size = 2; #1;
    check("i_accept", {30'd0, inst_addr_ok, data_addr_ok}, 32'd2);
    tick(); inst_req = 0;
    check("i_arvalid", {31'd0, arvalid}, 32'd1);
    check("i_araddr", araddr, 32'hBFC0_0000);
    check("i_arid_size", {24'd0, arid, 1'b0, arsize}, {24'd0, 4'd0, 1'b0, 3'd2});
    finish_read(1'b0, 32'h2408_0001);

    // simultaneous requests: data first, inst afterwards
    inst_req = 1; inst_addr = 32'h0000_1000; data_req = 1; data_addr = 32'h0000_2000; #1;
    check("both_accept", {30'd0, inst_addr_ok, data_addr_ok}, 32'd1);
    tick(); data_req = 0;
    check("both_d_ar", {arid, araddr[27:0]}, {4'd1, 28'h000_2000});
    check("both_no_inst_ok", {31'd0, inst_addr_ok}, 32'd0);
    finish_read(1'b1, 32'hDEAD_BEEF);
    check("both_i_accept", {30'd0, inst_addr_ok, data_addr_ok}, 32'd2);
    tick(); inst_req = 0;
    check("both_i_ar", {arid, araddr[27:0]}, {4'd0, 28'h000_1000});
    finish_read(1'b0, 32'h1234_5678);

    // byte and half writes, then a late W
    write_txn(32'h8000_0003, 2'd0, 32'h0000_00AB, 4'b1000, 0);
    write_txn(32'h8000_0002, 2'd1, 32'h0000_CDEF, 4'b1100, 0);
    write_txn(32'h8000_0001, 2'd0, 32'h0000_0011, 4'b0010, 0);
    write_txn(32'h8000_0004, 2'd2, 32'h1122_3344, 4'b1111, 3);

    // reset in RD_DATA
    data_req = 1; data_addr = 32'h0000_3000; data_size = 2; #1;
    tick(); data_req = 0;
    arready = 1; tick(); arready = 0;
    check("rr_rready", {31'd0, rready}, 32'd1);
    rst = 1; #1;
    check("rr_async", hs_bits(), 32'd0);
    tick(); rst = 0;
    rvalid = 1; rdata = 32'hBAD0_BAD0; data_req = 1; data_addr = 32'h0000_4000; #1;
    check("rr_stale", {29'd0, rready, inst_data_ok, data_data_ok}, 32'd0);
    check("rr_fresh_acc", {31'd0, data_addr_ok}, 32'd1);
    tick(); rvalid = 0; data_req = 0;
    check("rr_fresh_ar", araddr, 32'h0000_4000);
    finish_read(1'b1, 32'h0BAD_F00D);

    // back-to-back mixed traffic
    for (int n = 0; n < 20; n++) random_txn(n);
    check("exp_q_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
